// File: rtl/sync_fifo_asym_if.sv
// Handshake bundle for sync_fifo_asym: write/read requests, read data and every status output.
// master = producer/consumer side, slave = the FIFO.
interface sync_fifo_asym_if #(
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 32,
    parameter int WR_DEPTH     = 72,
    parameter int RD_DEPTH     = 18
);
    localparam int WCW = $clog2(WR_DEPTH) + 1;
    localparam int RCW = $clog2(RD_DEPTH) + 1;

    logic                    wr_en;
    logic [INPUT_WIDTH-1:0]  din;
    logic                    rd_en;
    logic                    valid;
    logic [OUTPUT_WIDTH-1:0] dout;
    logic                    full;
    logic                    empty;
    logic [WCW-1:0]          wr_data_count;
    logic [RCW-1:0]          rd_data_count;
    logic [WCW-1:0]          wr_data_space;
    logic [RCW-1:0]          rd_data_space;
    logic                    almost_full;
    logic                    almost_empty;
    logic                    prog_full;
    logic                    prog_empty;
    logic                    overflow;
    logic                    underflow;
    logic                    wr_ack;
    logic                    sbiterr;
    logic                    dbiterr;

    modport master (
        output wr_en, din, rd_en,
        input  valid, dout, full, empty, wr_data_count, rd_data_count,
               wr_data_space, rd_data_space, almost_full, almost_empty,
               prog_full, prog_empty, overflow, underflow, wr_ack, sbiterr, dbiterr
    );

    modport slave (
        input  wr_en, din, rd_en,
        output valid, dout, full, empty, wr_data_count, rd_data_count,
               wr_data_space, rd_data_space, almost_full, almost_empty,
               prog_full, prog_empty, overflow, underflow, wr_ack, sbiterr, dbiterr
    );
endinterface

// File: rtl/sync_fifo_asym.sv
// Single-clock FIFO with integer-ratio width conversion, STD/FWFT read modes and XPM-style status.
// Define SYNC_FIFO_ASYM_CHECK_EN to compile in simulation-only configuration and overflow/underflow checks.
module sync_fifo_asym #(
    parameter int          INPUT_WIDTH       = 8,
    parameter int          OUTPUT_WIDTH      = 32,
    parameter int          WR_DEPTH          = 72,
    parameter int          RD_DEPTH          = 18,
    parameter string       MODE              = "FWFT",
    parameter string       DIRECTION         = "LSB",
    parameter string       ECC_MODE          = "no_ecc",
    parameter int          PROG_FULL_THRESH  = 15,
    parameter int          PROG_EMPTY_THRESH = 10,
    parameter logic [15:0] USE_ADV_FEATURES  = 16'h1F1F
) (
    input logic            clock,
    input logic            reset,
    sync_fifo_asym_if.slave bus
);
    // Storage is R banks of unit-wide RAM; a unit index u lives in bank u%R, row u/R.
    localparam bit PACK       = (INPUT_WIDTH <= OUTPUT_WIDTH);
    localparam int UW         = PACK ? INPUT_WIDTH : OUTPUT_WIDTH;
    localparam int R          = PACK ? OUTPUT_WIDTH / INPUT_WIDTH : INPUT_WIDTH / OUTPUT_WIDTH;
    localparam int ROWS       = PACK ? RD_DEPTH : WR_DEPTH;
    localparam int NUNITS     = ROWS * R;
    localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW         = (R > 1) ? $clog2(R) : 1;
    localparam int CW         = $clog2(NUNITS + 1);
    localparam int WCW        = $clog2(WR_DEPTH) + 1;
    localparam int RCW        = $clog2(RD_DEPTH) + 1;
    localparam int WR_UNITS   = PACK ? 1 : R;
    localparam int RD_UNITS   = PACK ? R : 1;
    localparam bit IS_FWFT    = (MODE == "FWFT");
    localparam bit LSB_FIRST  = (DIRECTION == "LSB");
    localparam bit ECC_EN     = (ECC_MODE != "no_ecc");

    logic [RW-1:0]           wr_row_q, wr_row_d, rd_row_q, rd_row_d;
    logic [SW-1:0]           wr_sub_q, wr_sub_d, rd_sub_q, rd_sub_d;
    logic [CW-1:0]           units_q, units_d;
    logic [WCW-1:0]          wr_count_q, wr_count_d;
    logic [RCW-1:0]          rd_count_q, rd_count_d;
    logic                    full_q, full_d, empty_q, empty_d;
    logic                    almost_full_q, almost_full_d, almost_empty_q, almost_empty_d;
    logic                    prog_full_q, prog_full_d, prog_empty_q, prog_empty_d;
    logic                    overflow_q, underflow_q, wr_ack_q, valid_q;
    logic [OUTPUT_WIDTH-1:0] dout_q;
    logic [OUTPUT_WIDTH-1:0] head_word;
    logic [UW-1:0]           bank_rd [R];
    logic                    wr_acc, rd_acc;
    int                      units_n, wr_words, rd_words;

    assign wr_acc = bus.wr_en & ~full_q;
    assign rd_acc = bus.rd_en & ~empty_q;

    always_comb begin
        wr_row_d = wr_row_q;
        wr_sub_d = wr_sub_q;
        rd_row_d = rd_row_q;
        rd_sub_d = rd_sub_q;
        // The narrow side steps one unit at a time; the wide side steps a whole row.
        if (wr_acc) begin
            if (PACK && (wr_sub_q != SW'(R - 1))) begin
                wr_sub_d = wr_sub_q + SW'(1);
            end else begin
                wr_sub_d = '0;
                wr_row_d = (wr_row_q == RW'(ROWS - 1)) ? '0 : wr_row_q + RW'(1);
            end
        end
        if (rd_acc) begin
            if (!PACK && (rd_sub_q != SW'(R - 1))) begin
                rd_sub_d = rd_sub_q + SW'(1);
            end else begin
                rd_sub_d = '0;
                rd_row_d = (rd_row_q == RW'(ROWS - 1)) ? '0 : rd_row_q + RW'(1);
            end
        end

        units_n  = int'(units_q) + (wr_acc ? WR_UNITS : 0) - (rd_acc ? RD_UNITS : 0);
        // A wide write row stays occupied until its last unit is read, hence the ceiling.
        wr_words = PACK ? units_n : (units_n + R - 1) / R;
        rd_words = PACK ? units_n / R : units_n;

        units_d        = CW'(units_n);
        wr_count_d     = WCW'(wr_words);
        rd_count_d     = RCW'(rd_words);
        full_d         = (wr_words == WR_DEPTH);
        almost_full_d  = (wr_words == WR_DEPTH - 1);
        prog_full_d    = (wr_words >= PROG_FULL_THRESH);
        empty_d        = (rd_words == 0);
        almost_empty_d = (rd_words == 1);
        prog_empty_d   = (rd_words <= PROG_EMPTY_THRESH);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_row_q       <= '0;
            wr_sub_q       <= '0;
            rd_row_q       <= '0;
            rd_sub_q       <= '0;
            units_q        <= '0;
            wr_count_q     <= '0;
            rd_count_q     <= '0;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            prog_full_q    <= 1'b0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b0;
            prog_empty_q   <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            wr_ack_q       <= 1'b0;
            valid_q        <= 1'b0;
            dout_q         <= '0;
        end else begin
            wr_row_q       <= wr_row_d;
            wr_sub_q       <= wr_sub_d;
            rd_row_q       <= rd_row_d;
            rd_sub_q       <= rd_sub_d;
            units_q        <= units_d;
            wr_count_q     <= wr_count_d;
            rd_count_q     <= rd_count_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            prog_full_q    <= prog_full_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            prog_empty_q   <= prog_empty_d;
            overflow_q     <= bus.wr_en & full_q;
            underflow_q    <= bus.rd_en & empty_q;
            wr_ack_q       <= wr_acc;
            valid_q        <= !IS_FWFT && rd_acc;
            if (!IS_FWFT && rd_acc) begin
                dout_q <= head_word;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < R; gi++) begin : g_bank
            // LANE is where this bank's unit sits inside the wide word.
            localparam int LANE = LSB_FIRST ? gi : R - 1 - gi;
            logic [UW-1:0] mem [ROWS];
            logic          bank_we;
            logic [UW-1:0] bank_wdata;

            if (PACK) begin : g_pack
                assign bank_we    = wr_acc && (wr_sub_q == SW'(gi));
                assign bank_wdata = bus.din;
                assign head_word[LANE*UW +: UW] = bank_rd[gi];
            end else begin : g_unpack
                assign bank_we    = wr_acc;
                assign bank_wdata = bus.din[LANE*UW +: UW];
            end

            always_ff @(posedge clock) begin
                if (bank_we) begin
                    mem[wr_row_q] <= bank_wdata;
                end
            end

            assign bank_rd[gi] = mem[rd_row_q];
        end

        if (!PACK) begin : g_unpack_sel
            assign head_word = bank_rd[rd_sub_q];
        end
    endgenerate

    assign bus.full          = full_q;
    assign bus.empty         = empty_q;
    assign bus.dout          = IS_FWFT ? (empty_q ? '0 : head_word) : dout_q;
    assign bus.valid         = USE_ADV_FEATURES[12] & (IS_FWFT ? ~empty_q : valid_q);
    assign bus.wr_data_count = USE_ADV_FEATURES[2] ? wr_count_q : '0;
    assign bus.rd_data_count = USE_ADV_FEATURES[10] ? rd_count_q : '0;
    assign bus.wr_data_space = WCW'(WR_DEPTH) - wr_count_q;
    assign bus.rd_data_space = RCW'(RD_DEPTH) - rd_count_q;
    assign bus.overflow      = USE_ADV_FEATURES[0] & overflow_q;
    assign bus.prog_full     = USE_ADV_FEATURES[1] & prog_full_q;
    assign bus.almost_full   = USE_ADV_FEATURES[3] & almost_full_q;
    assign bus.wr_ack        = USE_ADV_FEATURES[4] & wr_ack_q;
    assign bus.underflow     = USE_ADV_FEATURES[8] & underflow_q;
    assign bus.prog_empty    = USE_ADV_FEATURES[9] & prog_empty_q;
    assign bus.almost_empty  = USE_ADV_FEATURES[11] & almost_empty_q;
    // No ECC encoder exists, so the error flags stay low.
    assign bus.sbiterr       = ECC_EN & 1'b0;
    assign bus.dbiterr       = ECC_EN & 1'b0;

`ifdef SYNC_FIFO_ASYM_CHECK_EN
    initial begin
        if (WR_DEPTH * INPUT_WIDTH != RD_DEPTH * OUTPUT_WIDTH)
            $error("sync_fifo_asym: WR_DEPTH*INPUT_WIDTH != RD_DEPTH*OUTPUT_WIDTH");
        if ((PACK ? (OUTPUT_WIDTH % INPUT_WIDTH) : (INPUT_WIDTH % OUTPUT_WIDTH)) != 0)
            $error("sync_fifo_asym: widths are not an integer ratio");
    end

    always @(posedge clock) begin
        if (reset && bus.wr_en && full_q)
            $error("sync_fifo_asym: overflow");
        if (reset && bus.rd_en && empty_q)
            $error("sync_fifo_asym: underflow");
    end
`else
    // Default build carries no checking logic.
`endif
endmodule

// File: tb/tb_sync_fifo_asym.sv
// Bench for sync_fifo_asym: FWFT/LSB default instance driven from a vector table and a unit-count
// model with a word scoreboard, plus an STD/MSB instance for registered-read behaviour.
module tb_sync_fifo_asym;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sync_fifo_asym_if #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(32), .WR_DEPTH(72), .RD_DEPTH(18)) a_if ();
    sync_fifo_asym_if #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(32), .WR_DEPTH(72), .RD_DEPTH(18)) b_if ();

    sync_fifo_asym dut_a (.clock(clk), .reset(rst_n), .bus(a_if.slave));
    sync_fifo_asym #(.MODE("STD"), .DIRECTION("MSB")) dut_b (.clock(clk), .reset(rst_n), .bus(b_if.slave));

    int checks = 0;
    int errors = 0;

    // Model of instance A: unit count, partially assembled word, completed-word scoreboard.
    int          m_units = 0;
    int          pcnt_a  = 0;
    logic [31:0] part_a  = '0;
    logic [31:0] sbq [$];

    // Model of instance B (MSB packing, registered read).
    int          b_units = 0;
    int          pcnt_b  = 0;
    logic [31:0] part_b  = '0;
    logic [31:0] last_b  = '0;
    logic [31:0] sbq_b [$];

    typedef struct {
        bit          we;
        logic [7:0]  d;
        bit          re;
        int          ewc;
        int          erc;
        bit          evalid;
        logic [31:0] edout;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_a(input bit exp_ack, input bit exp_ovf, input bit exp_unf);
        int wc;
        int rc;
        wc = m_units;
        rc = m_units / 4;
        chk("a_wr_data_count", 64'(a_if.wr_data_count), 64'(wc));
        chk("a_rd_data_count", 64'(a_if.rd_data_count), 64'(rc));
        chk("a_wr_data_space", 64'(a_if.wr_data_space), 64'(72 - wc));
        chk("a_rd_data_space", 64'(a_if.rd_data_space), 64'(18 - rc));
        chk("a_full",          64'(a_if.full),          64'(wc == 72));
        chk("a_almost_full",   64'(a_if.almost_full),   64'(wc == 71));
        chk("a_prog_full",     64'(a_if.prog_full),     64'(wc >= 15));
        chk("a_empty",         64'(a_if.empty),         64'(rc == 0));
        chk("a_almost_empty",  64'(a_if.almost_empty),  64'(rc == 1));
        chk("a_prog_empty",    64'(a_if.prog_empty),    64'(rc <= 10));
        chk("a_wr_ack",        64'(a_if.wr_ack),        64'(exp_ack));
        chk("a_overflow",      64'(a_if.overflow),      64'(exp_ovf));
        chk("a_underflow",     64'(a_if.underflow),     64'(exp_unf));
        chk("a_sbiterr",       64'(a_if.sbiterr | a_if.dbiterr), 64'(0));
        chk("a_valid",         64'(a_if.valid),         64'(rc > 0));
        if (rc > 0) chk("a_dout", 64'(a_if.dout), 64'(sbq[0]));
    endtask

    task automatic cyc_a(input bit we, input logic [7:0] d, input bit re);
        bit acc_w, acc_r, ovf, unf;
        logic [31:0] popped;
        acc_w = we && (m_units < 72);
        acc_r = re && (m_units >= 4);
        ovf   = we && (m_units >= 72);
        unf   = re && (m_units < 4);
        a_if.wr_en = we;
        a_if.din   = d;
        a_if.rd_en = re;
        @(posedge clk);
        #1;
        a_if.wr_en = 1'b0;
        a_if.rd_en = 1'b0;
        popped = '0;
        if (acc_r) begin
            popped = sbq.pop_front();
            m_units -= 4;
        end
        if (acc_w) begin
            part_a[8*pcnt_a +: 8] = d;
            pcnt_a++;
            m_units++;
            if (pcnt_a == 4) begin
                sbq.push_back(part_a);
                pcnt_a = 0;
                part_a = '0;
            end
        end
        $display("[A] wr=%0b din=0x%02h rd=%0b popped=0x%08h units=%0d", we, d, re, popped, m_units);
        check_a(acc_w, ovf, unf);
    endtask

    task automatic cyc_b(input bit we, input logic [7:0] d, input bit re);
        bit acc_w, acc_r, unf;
        logic [31:0] exp_word;
        acc_w = we && (b_units < 72);
        acc_r = re && (b_units >= 4);
        unf   = re && (b_units < 4);
        b_if.wr_en = we;
        b_if.din   = d;
        b_if.rd_en = re;
        @(posedge clk);
        #1;
        b_if.wr_en = 1'b0;
        b_if.rd_en = 1'b0;
        if (acc_r) begin
            exp_word = sbq_b.pop_front();
            b_units -= 4;
            last_b = exp_word;
            chk("b_valid", 64'(b_if.valid), 64'(1));
            $display("[B] read dout=0x%08h expected=0x%08h", b_if.dout, exp_word);
        end else begin
            chk("b_valid", 64'(b_if.valid), 64'(0));
            $display("[B] wr=%0b din=0x%02h rd=%0b units=%0d", we, d, re, b_units + (acc_w ? 1 : 0));
        end
        chk("b_dout", 64'(b_if.dout), 64'(last_b));
        if (acc_w) begin
            part_b = {part_b[23:0], d};
            pcnt_b++;
            b_units++;
            if (pcnt_b == 4) begin
                sbq_b.push_back(part_b);
                pcnt_b = 0;
                part_b = '0;
            end
        end
        chk("b_rd_data_count", 64'(b_if.rd_data_count), 64'(b_units / 4));
        chk("b_empty",         64'(b_if.empty),         64'(b_units < 4));
        chk("b_underflow",     64'(b_if.underflow),     64'(unf));
    endtask

    task automatic reset_models();
        m_units = 0; pcnt_a = 0; part_a = '0; sbq.delete();
        b_units = 0; pcnt_b = 0; part_b = '0; last_b = '0; sbq_b.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 8'h23, 1'b0, 1, 0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 8'h24, 1'b0, 2, 0, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 8'h25, 1'b0, 3, 0, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 8'h26, 1'b0, 4, 1, 1'b1, 32'h26252423};
        tbl[4] = '{1'b1, 8'h27, 1'b0, 5, 1, 1'b1, 32'h26252423};
        tbl[5] = '{1'b1, 8'h28, 1'b1, 2, 0, 1'b0, 32'h0};
        tbl[6] = '{1'b1, 8'h29, 1'b0, 3, 0, 1'b0, 32'h0};
        tbl[7] = '{1'b1, 8'h2a, 1'b0, 4, 1, 1'b1, 32'h2a292827};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 0, 0, 1'b0, 32'h0};

        a_if.wr_en = 1'b0; a_if.din = '0; a_if.rd_en = 1'b0;
        b_if.wr_en = 1'b0; b_if.din = '0; b_if.rd_en = 1'b0;
        rst_n = 1'b0;
        #12;
        check_a(1'b0, 1'b0, 1'b0);
        chk("a_reset_dout", 64'(a_if.dout), 64'(0));
        chk("b_reset_valid", 64'(b_if.valid), 64'(0));
        chk("b_reset_dout", 64'(b_if.dout), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Vector table: packing, FWFT presentation, simultaneous read/write.
        for (int i = 0; i < 9; i++) begin
            cyc_a(tbl[i].we, tbl[i].d, tbl[i].re);
            chk("tbl_wr_data_count", 64'(a_if.wr_data_count), 64'(tbl[i].ewc));
            chk("tbl_rd_data_count", 64'(a_if.rd_data_count), 64'(tbl[i].erc));
            chk("tbl_valid", 64'(a_if.valid), 64'(tbl[i].evalid));
            if (tbl[i].evalid) chk("tbl_dout", 64'(a_if.dout), 64'(tbl[i].edout));
        end

        // Fill to full, then one write too many.
        for (int i = 0; i < 72; i++) cyc_a(1'b1, 8'(i + 1), 1'b0);
        chk("fill_full", 64'(a_if.full), 64'(1));
        cyc_a(1'b1, 8'hee, 1'b0);
        chk("fill_overflow", 64'(a_if.overflow), 64'(1));
        chk("fill_count_held", 64'(a_if.wr_data_count), 64'(72));
        cyc_a(1'b0, 8'h00, 1'b0);

        // Drain completely, then one read too many.
        for (int i = 0; i < 18; i++) cyc_a(1'b0, 8'h00, 1'b1);
        chk("drain_empty", 64'(a_if.empty), 64'(1));
        cyc_a(1'b0, 8'h00, 1'b1);
        chk("drain_underflow", 64'(a_if.underflow), 64'(1));
        cyc_a(1'b0, 8'h00, 1'b0);

        // Streaming: reads start five cycles after writes.
        for (int i = 0; i < 40; i++) cyc_a(1'b1, 8'(8'h40 + i), i >= 5);
        for (int k = 0; k < 20 && m_units >= 4; k++) cyc_a(1'b0, 8'h00, 1'b1);

        // Reset with a partial word stored.
        for (int i = 0; i < 3; i++) cyc_a(1'b1, 8'(8'h51 + i), 1'b0);
        rst_n = 1'b0;
        #2;
        reset_models();
        check_a(1'b0, 1'b0, 1'b0);
        chk("rst_mid_dout", 64'(a_if.dout), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc_a(1'b1, 8'(8'h23 + i), 1'b0);
        chk("rst_mid_repack", 64'(a_if.dout), 64'(32'h26252423));
        for (int k = 0; k < 4 && m_units >= 4; k++) cyc_a(1'b0, 8'h00, 1'b1);

        // STD / MSB instance.
        for (int i = 0; i < 4; i++) cyc_b(1'b1, 8'(8'h23 + i), 1'b0);
        cyc_b(1'b0, 8'h00, 1'b1);
        chk("b_msb_word", 64'(b_if.dout), 64'(32'h23242526));
        cyc_b(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) cyc_b(1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 3; i++) cyc_b(1'b0, 8'h00, 1'b1);
        cyc_b(1'b0, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
